sram_bus_model: RTL and testbench

Parametrised, clocked bus-functional model of the external multi-bank asynchronous SRAM, instantiated in board-level benches in place of the fixed counter pattern driven onto the SRAM data bus. It decodes chip selects per bank, stores writes, returns reads after a programmable latency, and offers counter and address-echo pattern modes. It also counts accesses and flags bus-protocol violations for the bench to check.

---
 rtl/sram_bus_model_pkg.sv | 15 +
 rtl/sram_rd_pipe.sv | 39 +++
 rtl/sram_bus_model.sv | 177 +++++++++++++++++
 tb/tb_sram_bus_model.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_model_pkg.sv
// Shared constants for the SRAM bus-functional model: pattern modes and read-latency bounds.
package sram_bus_model_pkg;

   localparam logic [1:0] MODE_COUNTER = 2'd0;
   localparam logic [1:0] MODE_MEMORY  = 2'd1;
   localparam logic [1:0] MODE_ECHO    = 2'd2;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 8;

   function automatic bit rd_lat_ok(input int unsigned lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Valid/data delay line for read returns; output reflects the input RD_LAT edges earlier.
module sram_rd_pipe #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_flush,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic [RD_LAT-1:0] r_valid;
   logic [DATA_W-1:0] r_data [RD_LAT];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_valid <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            r_data[i] <= '0;
         end
      end else if (i_flush) begin
         r_valid <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_data[0]  <= i_data;
         for (int i = 1; i < RD_LAT; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
         end
      end
   end

   assign o_valid = r_valid[RD_LAT-1];
   assign o_data  = r_data[RD_LAT-1];

endmodule

// File: rtl/sram_bus_model.sv
// Bus-functional model of a multi-bank asynchronous SRAM: select decode, backing store,
// pattern modes, programmable read latency, access counters and protocol-violation checks.
module sram_bus_model
   import sram_bus_model_pkg::*;
#(
   parameter int unsigned ADDR_W     = 21,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned BANKS      = 4,
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic              i_brd_clk,
   input  logic              i_reset_n,
   input  logic [BANKS-1:0]  i_sram_cs_n,
   input  logic              i_sram_read_n,
   input  logic              i_sram_write_n,
   input  logic [ADDR_W-1:0] i_sram_addr,
   inout  wire  [DATA_W-1:0] io_sram_data,
   input  logic [1:0]        i_mode,
   output logic [15:0]       o_rd_count,
   output logic [15:0]       o_wr_count,
   output logic [7:0]        o_err_count,
   output logic              o_err_flag
);

   localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;

   if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
      $error("sram_bus_model: RD_LAT must be within 1..8");
   end

   logic [DATA_W-1:0]     r_mem [BANKS*DEPTH];

   logic [BANKS-1:0]      w_sel;
   logic                  w_any_sel, w_one_sel;
   logic [BANK_W-1:0]     w_bank;
   logic [DEPTH_LOG2-1:0] w_addr_lo;
   logic                  w_rd_act, w_wr_act;
   logic                  w_v_both, w_v_multi, w_v_cs_chg, w_viol;
   logic [1:0]            w_viol_n;
   logic                  w_commit, w_bypass, w_rd_new;
   logic [DATA_W-1:0]     w_mem_word, w_fetch;
   logic                  w_pipe_valid, w_drive;
   logic [DATA_W-1:0]     w_pipe_data;
   logic [8:0]            w_err_sum;

   logic                  r_wr_pend, r_wr_abort;
   logic [BANK_W-1:0]     r_wr_bank;
   logic [DEPTH_LOG2-1:0] r_wr_addr;
   logic [DATA_W-1:0]     r_wr_data;
   logic [BANKS-1:0]      r_cs_n;
   logic                  r_we_low;
   logic                  r_rd_act;
   logic [BANK_W-1:0]     r_rd_bank;
   logic [ADDR_W-1:0]     r_rd_addr;
   logic [DATA_W-1:0]     r_pat;
   logic [15:0]           r_rd_count, r_wr_count;
   logic [7:0]            r_err_count;
   logic                  r_err_flag;

   assign w_sel     = ~i_sram_cs_n;
   assign w_any_sel = |w_sel;
   assign w_one_sel = w_any_sel && ((w_sel & (w_sel - BANKS'(1))) == '0);
   assign w_addr_lo = i_sram_addr[DEPTH_LOG2-1:0];

   always_comb begin
      w_bank = '0;
      for (int i = 0; i < BANKS; i++) begin
         if (w_sel[i]) w_bank = BANK_W'(i);
      end
   end

   assign w_rd_act = w_one_sel && !i_sram_read_n && i_sram_write_n;
   assign w_wr_act = w_one_sel && !i_sram_write_n && i_sram_read_n;

   assign w_v_both   = !i_sram_read_n && !i_sram_write_n && w_any_sel;
   assign w_v_multi  = w_any_sel && !w_one_sel && (!i_sram_read_n || !i_sram_write_n);
   assign w_v_cs_chg = !i_sram_write_n && r_we_low && (i_sram_cs_n != r_cs_n);
   assign w_viol     = w_v_both || w_v_multi || w_v_cs_chg;
   assign w_viol_n   = {1'b0, w_v_both} + {1'b0, w_v_multi} + {1'b0, w_v_cs_chg};

   // WE rising edge: first sampled-high cycle after a latched write.
   assign w_commit = r_wr_pend && i_sram_write_n;
   assign w_bypass = w_commit && (r_wr_bank == w_bank) && (r_wr_addr == w_addr_lo);
   assign w_rd_new = w_rd_act &&
                     (!r_rd_act || (r_rd_bank != w_bank) || (r_rd_addr != i_sram_addr));

   always_comb begin
      w_mem_word = w_bypass ? r_wr_data : r_mem[{w_bank, w_addr_lo}];
      case (i_mode)
         MODE_COUNTER: w_fetch = r_pat + DATA_W'(1);
         MODE_ECHO:    w_fetch = i_sram_addr[DATA_W-1:0];
         MODE_MEMORY:  w_fetch = w_mem_word;
         default:      w_fetch = w_mem_word;
      endcase
   end

   always_ff @(posedge i_brd_clk) begin
      if (w_commit) r_mem[{r_wr_bank, r_wr_addr}] <= r_wr_data;
   end

   always_ff @(posedge i_brd_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_pend  <= 1'b0;
         r_wr_abort <= 1'b0;
         r_wr_bank  <= '0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else if (i_sram_write_n) begin
         r_wr_pend  <= 1'b0;
         r_wr_abort <= 1'b0;
      end else if (w_viol) begin
         // Poisoned until WE returns high so a later select cannot commit stale data.
         r_wr_pend  <= 1'b0;
         r_wr_abort <= 1'b1;
      end else if (w_wr_act && !r_wr_abort) begin
         r_wr_pend  <= 1'b1;
         r_wr_bank  <= w_bank;
         r_wr_addr  <= w_addr_lo;
         r_wr_data  <= io_sram_data;
      end
   end

   always_ff @(posedge i_brd_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cs_n      <= '1;
         r_we_low    <= 1'b0;
         r_rd_act    <= 1'b0;
         r_rd_bank   <= '0;
         r_rd_addr   <= '0;
         r_pat       <= '0;
         r_rd_count  <= '0;
         r_wr_count  <= '0;
         r_err_count <= '0;
         r_err_flag  <= 1'b0;
      end else begin
         r_cs_n    <= i_sram_cs_n;
         r_we_low  <= !i_sram_write_n;
         r_rd_act  <= w_rd_act;
         r_rd_bank <= w_bank;
         r_rd_addr <= i_sram_addr;
         r_pat     <= r_pat + DATA_W'(1);
         if (w_rd_new && (r_rd_count != '1)) r_rd_count <= r_rd_count + 16'd1;
         if (w_commit && (r_wr_count != '1)) r_wr_count <= r_wr_count + 16'd1;
         if (w_viol) begin
            r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            r_err_flag  <= 1'b1;
         end
      end
   end

   assign w_err_sum = {1'b0, r_err_count} + {7'd0, w_viol_n};

   sram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .i_clk     (i_brd_clk),
      .i_reset_n (i_reset_n),
      .i_flush   (!w_rd_act),
      .i_valid   (w_rd_act),
      .i_data    (w_fetch),
      .o_valid   (w_pipe_valid),
      .o_data    (w_pipe_data)
   );

   // Gated by live read_n/select so the bus frees in the same cycle OE rises.
   assign w_drive      = w_pipe_valid && !i_sram_read_n && w_one_sel;
   assign io_sram_data = w_drive ? w_pipe_data : {DATA_W{1'bz}};

   assign o_rd_count  = r_rd_count;
   assign o_wr_count  = r_wr_count;
   assign o_err_count = r_err_count;
   assign o_err_flag  = r_err_flag;

endmodule

// File: tb/tb_sram_bus_model.sv
// Directed bench for sram_bus_model: three instances (RD_LAT 1/3/4) share one stimulus set.
module tb_sram_bus_model;

   logic        clk;
   logic        rst_n;
   logic [3:0]  cs_n;
   logic        read_n;
   logic        write_n;
   logic [20:0] addr;
   logic [1:0]  mode;
   logic        drv_oe;
   logic [7:0]  drv;

   wire  [7:0]  bus1, bus3, bus4;
   logic [15:0] rd1, wr1, rd3, wr3, rd4, wr4;
   logic [7:0]  err1, err3, err4;
   logic        flag1, flag3, flag4;

   int n_chk = 0;
   int n_err = 0;

   // Undriven bus reads as 8'hFF through the pull-ups.
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (bus1[g]);
      pullup (bus3[g]);
      pullup (bus4[g]);
   end

   assign bus1 = drv_oe ? drv : 8'hzz;
   assign bus3 = drv_oe ? drv : 8'hzz;
   assign bus4 = drv_oe ? drv : 8'hzz;

   sram_bus_model #(.RD_LAT(1)) u_lat1 (
      .i_brd_clk (clk), .i_reset_n (rst_n), .i_sram_cs_n (cs_n), .i_sram_read_n (read_n),
      .i_sram_write_n (write_n), .i_sram_addr (addr), .io_sram_data (bus1), .i_mode (mode),
      .o_rd_count (rd1), .o_wr_count (wr1), .o_err_count (err1), .o_err_flag (flag1)
   );
   sram_bus_model #(.RD_LAT(3)) u_lat3 (
      .i_brd_clk (clk), .i_reset_n (rst_n), .i_sram_cs_n (cs_n), .i_sram_read_n (read_n),
      .i_sram_write_n (write_n), .i_sram_addr (addr), .io_sram_data (bus3), .i_mode (mode),
      .o_rd_count (rd3), .o_wr_count (wr3), .o_err_count (err3), .o_err_flag (flag3)
   );
   sram_bus_model #(.RD_LAT(4)) u_lat4 (
      .i_brd_clk (clk), .i_reset_n (rst_n), .i_sram_cs_n (cs_n), .i_sram_read_n (read_n),
      .i_sram_write_n (write_n), .i_sram_addr (addr), .io_sram_data (bus4), .i_mode (mode),
      .o_rd_count (rd4), .o_wr_count (wr4), .o_err_count (err4), .o_err_flag (flag4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cs_n = 4'hF; read_n = 1'b1; write_n = 1'b1; drv_oe = 1'b0;
   endtask

   task automatic test_reset();
      n_chk++; if (rd1 !== 16'd0) begin n_err++; $display("FAIL reset_rd got %0d want 0", rd1); end
      n_chk++; if (wr1 !== 16'd0) begin n_err++; $display("FAIL reset_wr got %0d want 0", wr1); end
      n_chk++; if (err1 !== 8'd0) begin n_err++; $display("FAIL reset_err got %0d want 0", err1); end
      n_chk++; if (flag1 !== 1'b0) begin n_err++; $display("FAIL reset_flag got %b want 0", flag1); end
      n_chk++; if (bus1 !== 8'hFF) begin n_err++; $display("FAIL reset_bus got %h want ff", bus1); end
   endtask

   task automatic test_counter();
      logic [7:0] exp1;
      mode = 2'd0; cs_n = 4'b1110; addr = 21'd0; read_n = 1'b0;
      #1;
      n_chk++; if (bus1 !== 8'hFF) begin n_err++; $display("FAIL cnt_in_reset got %h want ff", bus1); end
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         exp1 = 8'(i);
         n_chk++;
         if (bus1 !== exp1) begin n_err++; $display("FAIL cnt_seq%0d got %h want %h", i, bus1, exp1); end
         if (i == 3) begin
            n_chk++; if (bus3 !== 8'h01) begin n_err++; $display("FAIL cnt_lat3 got %h want 01", bus3); end
            n_chk++; if (bus4 !== 8'hFF) begin n_err++; $display("FAIL cnt_lat4_early got %h want ff", bus4); end
         end
      end
      n_chk++; if (bus4 !== 8'h02) begin n_err++; $display("FAIL cnt_lat4 got %h want 02", bus4); end
      n_chk++; if (rd1 !== 16'd1) begin n_err++; $display("FAIL cnt_rd got %0d want 1", rd1); end
      read_n = 1'b1;
      #1;
      n_chk++; if (bus1 !== 8'hFF) begin n_err++; $display("FAIL cnt_release got %h want ff", bus1); end
      idle();
      step();
   endtask

   task automatic test_mem_write_read();
      mode = 2'd1; cs_n = 4'b1011; addr = 21'h003; write_n = 1'b0; drv_oe = 1'b1; drv = 8'hA5;
      step();
      write_n = 1'b1; drv_oe = 1'b0;
      step();
      n_chk++; if (wr1 !== 16'd1) begin n_err++; $display("FAIL mem_wr got %0d want 1", wr1); end
      idle();
      step();
      cs_n = 4'b1011; addr = 21'h003; read_n = 1'b0;
      step();
      n_chk++; if (bus1 !== 8'hA5) begin n_err++; $display("FAIL mem_lat1 got %h want a5", bus1); end
      step();
      n_chk++; if (bus3 !== 8'hFF) begin n_err++; $display("FAIL mem_lat3_early got %h want ff", bus3); end
      step();
      n_chk++; if (bus3 !== 8'hA5) begin n_err++; $display("FAIL mem_lat3 got %h want a5", bus3); end
      n_chk++; if (bus4 !== 8'hFF) begin n_err++; $display("FAIL mem_lat4_early got %h want ff", bus4); end
      step();
      n_chk++; if (bus4 !== 8'hA5) begin n_err++; $display("FAIL mem_lat4 got %h want a5", bus4); end
      n_chk++; if (rd3 !== 16'd2) begin n_err++; $display("FAIL mem_rd got %0d want 2", rd3); end
      idle();
      step();
   endtask

   task automatic test_bypass();
      mode = 2'd1; cs_n = 4'b1110; addr = 21'h005; write_n = 1'b0; drv_oe = 1'b1; drv = 8'h3C;
      step();
      write_n = 1'b1; drv_oe = 1'b0; read_n = 1'b0;
      step();
      n_chk++; if (bus1 !== 8'h3C) begin n_err++; $display("FAIL bypass_data got %h want 3c", bus1); end
      n_chk++; if (wr1 !== 16'd2) begin n_err++; $display("FAIL bypass_wr got %0d want 2", wr1); end
      n_chk++; if (rd1 !== 16'd3) begin n_err++; $display("FAIL bypass_rd got %0d want 3", rd1); end
      idle();
      step();
   endtask

   task automatic test_echo();
      mode = 2'd2; cs_n = 4'b1101; addr = 21'h1F0C7; read_n = 1'b0;
      step();
      n_chk++; if (bus1 !== 8'hC7) begin n_err++; $display("FAIL echo_data got %h want c7", bus1); end
      read_n = 1'b1;
      #1;
      n_chk++; if (bus1 !== 8'hFF) begin n_err++; $display("FAIL echo_release got %h want ff", bus1); end
      n_chk++; if (rd1 !== 16'd4) begin n_err++; $display("FAIL echo_rd got %0d want 4", rd1); end
      idle();
      step();
   endtask

   task automatic test_violations();
      mode = 2'd1; cs_n = 4'b1110; addr = 21'h009; read_n = 1'b0; write_n = 1'b0;
      step();
      n_chk++; if (err1 !== 8'd1) begin n_err++; $display("FAIL viol_both_cnt got %0d want 1", err1); end
      n_chk++; if (flag1 !== 1'b1) begin n_err++; $display("FAIL viol_flag got %b want 1", flag1); end
      n_chk++; if (bus1 !== 8'hFF) begin n_err++; $display("FAIL viol_both_bus got %h want ff", bus1); end
      read_n = 1'b1; write_n = 1'b1;
      step();
      n_chk++; if (wr1 !== 16'd2) begin n_err++; $display("FAIL viol_both_commit got %0d want 2", wr1); end
      read_n = 1'b0; write_n = 1'b0;
      step();
      n_chk++; if (err1 !== 8'd2) begin n_err++; $display("FAIL viol_second got %0d want 2", err1); end
      idle();
      step();
      cs_n = 4'b1100; read_n = 1'b0;
      step();
      n_chk++; if (err1 !== 8'd3) begin n_err++; $display("FAIL viol_multi_cnt got %0d want 3", err1); end
      n_chk++; if (bus1 !== 8'hFF) begin n_err++; $display("FAIL viol_multi_bus got %h want ff", bus1); end
      n_chk++; if (rd1 !== 16'd4) begin n_err++; $display("FAIL viol_multi_rd got %0d want 4", rd1); end
      idle();
      step();
      cs_n = 4'b0111; addr = 21'h007; write_n = 1'b0; drv_oe = 1'b1; drv = 8'h5A;
      step();
      cs_n = 4'b1011;
      step();
      n_chk++; if (err1 !== 8'd4) begin n_err++; $display("FAIL viol_cschg_cnt got %0d want 4", err1); end
      idle();
      step();
      n_chk++; if (wr1 !== 16'd2) begin n_err++; $display("FAIL viol_cschg_commit got %0d want 2", wr1); end
      step();
   endtask

   task automatic test_err_saturate();
      cs_n = 4'b1110; read_n = 1'b0; write_n = 1'b0;
      for (int i = 0; i < 260; i++) step();
      idle();
      step();
      n_chk++; if (err1 !== 8'hFF) begin n_err++; $display("FAIL err_sat got %0d want 255", err1); end
      n_chk++; if (flag4 !== 1'b1) begin n_err++; $display("FAIL err_sat_flag got %b want 1", flag4); end
   endtask

   task automatic test_reset_mid_read();
      mode = 2'd2; cs_n = 4'b1101; addr = 21'h00012; read_n = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_chk++; if (bus4 !== 8'h12) begin n_err++; $display("FAIL rst_pre_data got %h want 12", bus4); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (bus4 !== 8'hFF) begin n_err++; $display("FAIL rst_bus got %h want ff", bus4); end
      n_chk++; if (rd4 !== 16'd0) begin n_err++; $display("FAIL rst_rd got %0d want 0", rd4); end
      n_chk++; if (err4 !== 8'd0) begin n_err++; $display("FAIL rst_err got %0d want 0", err4); end
      n_chk++; if (flag4 !== 1'b0) begin n_err++; $display("FAIL rst_flag got %b want 0", flag4); end
      addr = 21'h00034;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();
      n_chk++; if (bus4 !== 8'hFF) begin n_err++; $display("FAIL rst_refill_early got %h want ff", bus4); end
      step();
      n_chk++; if (bus4 !== 8'h34) begin n_err++; $display("FAIL rst_refill got %h want 34", bus4); end
      n_chk++; if (rd4 !== 16'd1) begin n_err++; $display("FAIL rst_refill_rd got %0d want 1", rd4); end
      idle();
      step();
   endtask

   initial begin
      rst_n = 1'b0; mode = 2'd0; addr = 21'd0; drv = 8'h00;
      idle();
      #23;
      test_reset();
      test_counter();
      test_mem_write_read();
      test_bypass();
      test_echo();
      test_violations();
      test_err_saturate();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
